gamma_sequencer: RTL and testbench

GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

---
 rtl/gamma_sequencer_pkg.sv | 25 ++
 rtl/gamma_sequencer_if.sv | 25 ++
 rtl/gamma_sequencer_pulse_gen.sv | 29 ++
 rtl/gamma_sequencer.sv | 152 +++++++++++++++
 tb/tb_gamma_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gamma_sequencer_pkg.sv
// Shared definitions for the gamma sequencer slice.
// Holds the FSM state encoding, the parameter defaults and the time
// encodings used on the operand and result time fields.
package gamma_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESET   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } gamma_state_t;

  localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
  localparam int DEF_PULSE_WIDTH       = 8;
  localparam int DEF_RST_CYCLES        = 2;

  // Width of every time field for the default gamma length.
  localparam int DEF_TW = $clog2(DEF_GAMMA_CYCLE_WIDTH) + 1;

  // Operand side: any time >= GAMMA_CYCLE_WIDTH means "no spike". This is
  // the canonical infinity for the default configuration. On the result
  // side "no spike" is reported as an all-ones res_time.
  localparam int INF_TIME = DEF_GAMMA_CYCLE_WIDTH;

endpackage

// File: rtl/gamma_sequencer_if.sv
// Request/result bus of the gamma sequencer.
//   cfg_valid/cfg_ready : request handshake, a_time/b_time operand ticks
//   res_valid           : one-cycle strobe qualifying res_time/res_spike
// master = requester (drives cfg_*), slave = gamma_sequencer.
interface gamma_sequencer_if #(
  parameter int TW = gamma_pkg::DEF_TW
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [TW-1:0] a_time;
  logic [TW-1:0] b_time;
  logic          res_valid;
  logic [TW-1:0] res_time;
  logic          res_spike;

  modport master (
    output cfg_valid, a_time, b_time,
    input  cfg_ready, res_valid, res_time, res_spike
  );

  modport slave (
    input  cfg_valid, a_time, b_time,
    output cfg_ready, res_valid, res_time, res_spike
  );
endinterface

// File: rtl/gamma_sequencer_pulse_gen.sv
// pulse_gen: registered operand pulse.
// Ports: aclk, grst (async, active-high), en (next cycle is in COMPUTE),
//        tick (tick value of the next cycle), launch (operand time),
//        pulse (registered, high while launch <= tick < launch+PULSE_WIDTH).
// Fed with next-cycle values so the registered pulse lines up with the
// cycle whose tick equals the launch time.
module pulse_gen #(
  parameter int TW          = gamma_pkg::DEF_TW,
  parameter int PULSE_WIDTH = gamma_pkg::DEF_PULSE_WIDTH
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          en,
  input  logic [TW-1:0] tick,
  input  logic [TW-1:0] launch,
  output logic          pulse
);
  logic in_window;

  // Compared in 32 bits so launch+PULSE_WIDTH cannot wrap. An infinite
  // launch time is never reached because tick stops at GAMMA_CYCLE_WIDTH-1.
  assign in_window = (int'(tick) >= int'(launch)) &&
                     (int'(tick) < int'(launch) + PULSE_WIDTH);

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) pulse <= 1'b0;
    else      pulse <= en && in_window;
  end
endmodule

// File: rtl/gamma_sequencer.sv
// gamma_sequencer: runs one race-logic gamma cycle per accepted request.
// Sequence: IDLE -> RESET (gamma_rst for RST_CYCLES) -> COMPUTE (ticks
// 0..GAMMA_CYCLE_WIDTH-1, operand pulses a/b launched) -> DONE (res_valid).
// Ports: aclk, grst (async, active-high), bus (gamma_sequencer_if.slave:
//        cfg handshake + result), gamma_rst/a/b to the datapath,
//        race_out from the datapath.
// Optional: define GAMMA_SPIKE_COUNT_EN to add the 16-bit saturating
//        spike_count output (DONE cycles that carried a spike).
module gamma_sequencer
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
  parameter int PULSE_WIDTH       = DEF_PULSE_WIDTH,
  parameter int RST_CYCLES        = DEF_RST_CYCLES
) (
  input  logic               aclk,
  input  logic               grst,
  gamma_sequencer_if.slave   bus,
  output logic               gamma_rst,
  output logic               a,
  output logic               b,
  input  logic               race_out
`ifdef GAMMA_SPIKE_COUNT_EN
  ,
  output logic [15:0]        spike_count
`endif
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(GAMMA_CYCLE_WIDTH - 1);

  gamma_state_t          state;
  logic [TW-1:0]         tick;
  logic [RW-1:0]         rst_cnt;
  logic [1:0][TW-1:0]    op_time;
  logic                  race_prev;
  logic                  found;
  logic [TW-1:0]         cap_time;
  logic [1:0]            pulse;

  logic                  handshake;
  logic                  last_rst;
  logic                  last_tick;
  logic                  edge_now;
  logic                  compute_next;
  logic [TW-1:0]         tick_next;

  assign handshake = bus.cfg_valid && bus.cfg_ready;

  always_comb begin
    last_rst     = (state == S_RESET) && (rst_cnt == RW'(RST_CYCLES - 1));
    last_tick    = (state == S_COMPUTE) && (tick == LAST_TICK);
    // Only the first rising edge of the gamma counts.
    edge_now     = (state == S_COMPUTE) && race_out && !race_prev && !found;
    compute_next = last_rst || ((state == S_COMPUTE) && !last_tick);
    tick_next    = (state == S_COMPUTE) ? tick + TW'(1) : '0;
  end

  // Operand pulse generators: index 0 drives a, index 1 drives b.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pulse
    pulse_gen #(
      .TW          (TW),
      .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulse (
      .aclk   (aclk),
      .grst   (grst),
      .en     (compute_next),
      .tick   (tick_next),
      .launch (op_time[gi]),
      .pulse  (pulse[gi])
    );
  end

  assign a = pulse[0];
  assign b = pulse[1];

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state         <= S_IDLE;
      tick          <= '0;
      rst_cnt       <= '0;
      op_time       <= '0;
      race_prev     <= 1'b0;
      found         <= 1'b0;
      cap_time      <= '0;
      gamma_rst     <= 1'b0;
      bus.cfg_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_time  <= '0;
      bus.res_spike <= 1'b0;
`ifdef GAMMA_SPIKE_COUNT_EN
      spike_count   <= '0;
`endif
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (handshake) begin
            op_time       <= {bus.b_time, bus.a_time};
            state         <= S_RESET;
            tick          <= '0;
            rst_cnt       <= '0;
            gamma_rst     <= 1'b1;
            bus.cfg_ready <= 1'b0;
          end else begin
            state         <= S_IDLE;
            bus.cfg_ready <= 1'b1;
          end
        end
        S_RESET: begin
          // Clearing the previous sample makes race_out already high at
          // tick 0 count as an edge.
          race_prev <= 1'b0;
          found     <= 1'b0;
          cap_time  <= '0;
          if (last_rst) begin
            state     <= S_COMPUTE;
            tick      <= '0;
            gamma_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_COMPUTE: begin
          race_prev <= race_out;
          if (edge_now) begin
            found    <= 1'b1;
            cap_time <= tick;
          end
          if (last_tick) begin
            // Fold in an edge seen on the final tick itself.
            state         <= S_DONE;
            bus.cfg_ready <= 1'b1;
            bus.res_valid <= 1'b1;
            bus.res_spike <= found || edge_now;
            bus.res_time  <= found ? cap_time : (edge_now ? tick : '1);
`ifdef GAMMA_SPIKE_COUNT_EN
            if ((found || edge_now) && (spike_count != 16'hFFFF))
              spike_count <= spike_count + 16'd1;
`endif
          end else begin
            tick <= tick_next;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.cfg_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed testbench for gamma_sequencer (G=16, P=8, R=2).
// The datapath is modelled by race_mode: 0 -> race_out=0,
// 1 -> race_out=a&~b, 2 -> race_out=1.
module tb_gamma_sequencer;
  import gamma_pkg::*;

  localparam int G  = 16;
  localparam int P  = 8;
  localparam int R  = 2;
  localparam int TW = 5;

  logic aclk = 1'b0;
  logic grst = 1'b1;
  always #5 aclk = ~aclk;

  gamma_sequencer_if #(.TW(TW)) bus ();

  logic gamma_rst;
  logic a;
  logic b;
  logic race_out;
  int   race_mode;
`ifdef GAMMA_SPIKE_COUNT_EN
  logic [15:0] spike_count;
`endif

  always_comb begin
    case (race_mode)
      1:       race_out = a & ~b;
      2:       race_out = 1'b1;
      default: race_out = 1'b0;
    endcase
  end

  gamma_sequencer #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (P),
    .RST_CYCLES        (R)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .bus         (bus),
    .gamma_rst   (gamma_rst),
    .a           (a),
    .b           (b),
    .race_out    (race_out)
`ifdef GAMMA_SPIKE_COUNT_EN
    ,
    .spike_count (spike_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Runs one gamma from IDLE; records 20 cycles starting with the first
  // RESET cycle (k=0,1 RESET, k=2..17 ticks 0..15, k=18 DONE, k=19 IDLE).
  task automatic run_gamma(input logic [TW-1:0] at, input logic [TW-1:0] bt,
                           input int mode,
                           output logic [19:0] gv, output logic [19:0] av,
                           output logic [19:0] bv, output logic [19:0] vv,
                           output logic [TW-1:0] rt, output logic rs);
    gv = '0; av = '0; bv = '0; vv = '0; rt = '0; rs = 1'b0;
    race_mode     = mode;
    bus.a_time    = at;
    bus.b_time    = bt;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      gv[k] = gamma_rst;
      av[k] = a;
      bv[k] = b;
      vv[k] = bus.res_valid;
      if (bus.res_valid) begin
        rt = bus.res_time;
        rs = bus.res_spike;
      end
      if (k < 19) step();
    end
    $display("gamma a_time=%0d b_time=%0d mode=%0d res_time=%0d res_spike=%0d",
             at, bt, mode, rt, rs);
  endtask

  task automatic test_reset();
    bus.cfg_valid = 1'b0;
    bus.a_time    = '0;
    bus.b_time    = '0;
    race_mode     = 0;
    grst          = 1'b1;
    step(); step();
    n_checks++;
    if ({gamma_rst, a, b, bus.res_valid, bus.res_spike, bus.cfg_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=000001",
               {gamma_rst, a, b, bus.res_valid, bus.res_spike, bus.cfg_ready});
    end
    n_checks++;
    if (bus.res_time !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_res_time got=%0d want=0", bus.res_time);
    end
    grst = 1'b0;
    step(); step();
    n_checks++;
    if ({gamma_rst, bus.res_valid, bus.cfg_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%b want=001", {gamma_rst, bus.res_valid, bus.cfg_ready});
    end
  endtask

  task automatic test_basic();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    run_gamma(5'd3, 5'd5, 1, gv, av, bv, vv, rt, rs);
    n_checks++;
    if (gv !== 20'h00003) begin n_fail++; $display("FAIL basic_gamma_rst got=%h want=00003", gv); end
    n_checks++;
    if (av !== 20'h01FE0) begin n_fail++; $display("FAIL basic_a got=%h want=01fe0", av); end
    n_checks++;
    if (bv !== 20'h07F80) begin n_fail++; $display("FAIL basic_b got=%h want=07f80", bv); end
    n_checks++;
    if (vv !== 20'h40000) begin n_fail++; $display("FAIL basic_res_valid got=%h want=40000", vv); end
    n_checks++;
    if ({rt, rs} !== {5'd3, 1'b1}) begin
      n_fail++; $display("FAIL basic_result got=%0d/%b want=3/1", rt, rs);
    end
  endtask

  task automatic test_infinity();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    run_gamma(TW'(INF_TIME), TW'(INF_TIME), 0, gv, av, bv, vv, rt, rs);
    n_checks++;
    if ((av | bv) !== 20'h0) begin n_fail++; $display("FAIL inf_pulses got a=%h b=%h want=0", av, bv); end
    n_checks++;
    if (vv !== 20'h40000) begin n_fail++; $display("FAIL inf_res_valid got=%h want=40000", vv); end
    n_checks++;
    if ({rt, rs} !== {5'h1F, 1'b0}) begin
      n_fail++; $display("FAIL inf_result got=%0d/%b want=31/0", rt, rs);
    end
  endtask

  task automatic test_tick_zero();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    // race_out already high when COMPUTE starts counts as an edge at tick 0.
    run_gamma(5'd0, TW'(INF_TIME), 2, gv, av, bv, vv, rt, rs);
    n_checks++;
    if (av !== 20'h003FC) begin n_fail++; $display("FAIL zero_a got=%h want=003fc", av); end
    n_checks++;
    if ({rt, rs} !== {5'd0, 1'b1}) begin
      n_fail++; $display("FAIL zero_result got=%0d/%b want=0/1", rt, rs);
    end
  endtask

  task automatic test_clip();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    run_gamma(5'd12, 5'd15, 1, gv, av, bv, vv, rt, rs);
    n_checks++;
    if (av !== 20'h3C000) begin n_fail++; $display("FAIL clip_a got=%h want=3c000", av); end
    n_checks++;
    if (bv !== 20'h20000) begin n_fail++; $display("FAIL clip_b got=%h want=20000", bv); end
    n_checks++;
    if ({rt, rs} !== {5'd12, 1'b1}) begin
      n_fail++; $display("FAIL clip_result got=%0d/%b want=12/1", rt, rs);
    end
    step(); step();
    n_checks++;
    if ({bus.res_time, bus.res_spike} !== {5'd12, 1'b1}) begin
      n_fail++; $display("FAIL clip_hold got=%0d/%b want=12/1", bus.res_time, bus.res_spike);
    end
  endtask

  task automatic test_back_to_back();
    int pos[3];
    int npulse = 0;
    logic rst_after_done = 1'b0;
    race_mode     = 1;
    bus.a_time    = 5'd3;
    bus.b_time    = 5'd5;
    bus.cfg_valid = 1'b1;
    step();
    for (int k = 0; k < 60; k++) begin
      if (bus.res_valid) begin
        if (npulse < 3) pos[npulse] = k;
        npulse++;
        $display("b2b res_valid at k=%0d res_time=%0d", k, bus.res_time);
      end
      if (k == 19) rst_after_done = gamma_rst;
      step();
    end
    bus.cfg_valid = 1'b0;
    for (int k = 0; k < 25; k++) step();
    n_checks++;
    if (npulse !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", npulse); end
    else begin
      n_checks++;
      if (pos[0] !== 18 || pos[1] !== 37 || pos[2] !== 56) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=18,37,56", pos[0], pos[1], pos[2]);
      end
    end
    n_checks++;
    if (rst_after_done !== 1'b1) begin n_fail++; $display("FAIL b2b_direct_reset got=%b want=1", rst_after_done); end
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got=%b want=1", bus.cfg_ready); end
  endtask

  task automatic test_grst_mid();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    int nvalid = 0;
    race_mode     = 1;
    bus.a_time    = 5'd3;
    bus.b_time    = 5'd5;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    // Now at tick 7: both operand pulses are active.
    n_checks++;
    if ({a, b} !== 2'b11) begin n_fail++; $display("FAIL grst_pre_ab got=%b want=11", {a, b}); end
    grst = 1'b1;
    #1;
    n_checks++;
    if ({gamma_rst, a, b, bus.res_valid, bus.cfg_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL grst_outputs got=%b want=00001", {gamma_rst, a, b, bus.res_valid, bus.cfg_ready});
    end
    n_checks++;
    if (bus.res_time !== 5'd0) begin n_fail++; $display("FAIL grst_res_time got=%0d want=0", bus.res_time); end
    step();
    grst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bus.res_valid) nvalid++;
      step();
    end
    n_checks++;
    if (nvalid !== 0) begin n_fail++; $display("FAIL grst_no_result got=%0d want=0", nvalid); end
    run_gamma(5'd3, 5'd5, 1, gv, av, bv, vv, rt, rs);
    n_checks++;
    if ({vv, rt, rs} !== {20'h40000, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL grst_recover got=%h/%0d/%b want=40000/3/1", vv, rt, rs);
    end
  endtask

`ifdef GAMMA_SPIKE_COUNT_EN
  task automatic test_spike_count();
    logic [19:0] gv, av, bv, vv;
    logic [TW-1:0] rt;
    logic rs;
    grst = 1'b1;
    step();
    grst = 1'b0;
    step();
    run_gamma(5'd3, 5'd5, 1, gv, av, bv, vv, rt, rs);
    run_gamma(TW'(INF_TIME), TW'(INF_TIME), 0, gv, av, bv, vv, rt, rs);
    run_gamma(5'd0, TW'(INF_TIME), 2, gv, av, bv, vv, rt, rs);
    n_checks++;
    if (spike_count !== 16'd2) begin n_fail++; $display("FAIL spike_count got=%0d want=2", spike_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_infinity();
    test_tick_zero();
    test_clip();
    test_back_to_back();
    test_grst_mid();
`ifdef GAMMA_SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
